// File: rtl/signal_frame_loader.sv
// Input staging for the 1-D CNN: packs FRAME_LEN signed samples into a flat frame bus and
// holds it until acknowledged. Define LOADER_OVERLAP_EN for 50 % frame overlap.
module signal_frame_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_W      = 11
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           sample_in,
  input  logic                            sample_valid,
  output logic                            sample_ready,
  input  logic                            frame_ack,
  output logic [FRAME_LEN*DATA_WIDTH-1:0] frame_out,
  output logic                            frame_valid,
  output logic [7:0]                      frame_cnt,
  output logic                            overrun
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int HALF  = FRAME_LEN / 2;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
`ifdef LOADER_OVERLAP_EN
  localparam logic [CNT_W-1:0] ACK_IDX = CNT_W'(HALF);
`else
  localparam logic [CNT_W-1:0] ACK_IDX = {CNT_W{1'b0}};
`endif

  typedef enum logic [0:0] {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        wr_idx_r;
  logic [7:0]              frame_cnt_r;
  logic                    sample_ready_r, frame_valid_r, overrun_r;
  logic                    accept_s, last_s, ack_s;
  logic [DATA_WIDTH-1:0]   slot_r [FRAME_LEN];

  assign accept_s = sample_valid & sample_ready_r;
  assign last_s   = accept_s & (wr_idx_r == LAST_IDX);
  assign ack_s    = (state_r == FULL) & frame_ack;

  // Next-state decode: the last accepted slot completes a frame, ack releases it
  always_comb begin
    state_s = state_r;
    case (state_r)
      FILL: begin
        if (last_s) state_s = FULL;
        else        state_s = FILL;
      end
      FULL: begin
        if (frame_ack) state_s = FILL;
        else           state_s = FULL;
      end
      default: state_s = FILL;
    endcase
  end

  // Control registers; ready/valid are registered decodes of the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= FILL;
      sample_ready_r <= 1'b1;
      frame_valid_r  <= 1'b0;
      wr_idx_r       <= {CNT_W{1'b0}};
      frame_cnt_r    <= 8'd0;
      overrun_r      <= 1'b0;
    end else begin
      state_r        <= state_s;
      sample_ready_r <= (state_s == FILL);
      frame_valid_r  <= (state_s == FULL);
      if (sample_valid && !sample_ready_r) overrun_r <= 1'b1;
      if (last_s) begin
        wr_idx_r    <= {CNT_W{1'b0}};
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else if (accept_s) begin
        wr_idx_r <= wr_idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (ack_s) begin
        wr_idx_r <= ACK_IDX;
      end
    end
  end

  // Sample storage; with overlap the upper half slides down on ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FRAME_LEN; i++) slot_r[i] <= {DATA_WIDTH{1'b0}};
    end else if (accept_s) begin
      slot_r[wr_idx_r[IDX_W-1:0]] <= sample_in;
`ifdef LOADER_OVERLAP_EN
    end else if (ack_s) begin
      for (int i = 0; i < HALF; i++) slot_r[i] <= slot_r[i + HALF];
`endif
    end
  end

  for (genvar g = 0; g < FRAME_LEN; g++) begin : g_pack
    assign frame_out[g*DATA_WIDTH +: DATA_WIDTH] = slot_r[g];
  end

  assign sample_ready = sample_ready_r;
  assign frame_valid  = frame_valid_r;
  assign frame_cnt    = frame_cnt_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_signal_frame_loader.sv
// Randomized self-checking bench for signal_frame_loader against a queue-based frame model.
module tb_signal_frame_loader;
  localparam int DW  = 16;
  localparam int FL  = 1024;
  localparam int SFL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, sample_valid, frame_ack, sample_ready, frame_valid, overrun;
  logic [DW-1:0]     sample_in;
  logic [FL*DW-1:0]  frame_out;
  logic [7:0]        frame_cnt;

  logic              s_valid, s_ack, s_ready, s_fvalid, s_ovr;
  logic [DW-1:0]     s_in;
  logic [SFL*DW-1:0] s_frame;
  logic [7:0]        s_cnt;

  signal_frame_loader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_W(11)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .frame_ack(frame_ack), .frame_out(frame_out),
    .frame_valid(frame_valid), .frame_cnt(frame_cnt), .overrun(overrun));

  signal_frame_loader #(.DATA_WIDTH(DW), .FRAME_LEN(SFL), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .sample_in(s_in), .sample_valid(s_valid),
    .sample_ready(s_ready), .frame_ack(s_ack), .frame_out(s_frame),
    .frame_valid(s_fvalid), .frame_cnt(s_cnt), .overrun(s_ovr));

  int vectors = 0;
  int errors  = 0;

  // Model: the current frame is the queue of accepted samples still in play.
  logic [DW-1:0] mq[$];
  bit            m_full;
  int            m_cnt;
  bit            m_ovr;

  task automatic model_reset();
    mq.delete();
    m_full = 1'b0;
    m_cnt  = 0;
    m_ovr  = 1'b0;
  endtask

  function automatic logic [FL*DW-1:0] exp_frame();
    logic [FL*DW-1:0] e;
    e = '0;
    for (int i = 0; i < mq.size(); i++) e[i*DW +: DW] = mq[i];
    return e;
  endfunction

  function automatic logic [10:0] exp_status();
    return {m_full, !m_full, m_ovr, 8'(m_cnt)};
  endfunction

  // One clock edge with the current inputs; model applies the frame rules.
  task automatic cyc();
    @(posedge clk);
    if (!m_full) begin
      if (sample_valid) begin
        mq.push_back(sample_in);
        if (mq.size() == FL) begin
          m_full = 1'b1;
          m_cnt  = (m_cnt + 1) % 256;
        end
      end
    end else begin
      if (sample_valid) m_ovr = 1'b1;
      if (frame_ack) begin
        m_full = 1'b0;
`ifdef LOADER_OVERLAP_EN
        repeat (FL/2) void'(mq.pop_front());
`else
        mq.delete();
`endif
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; sample_valid = 1'b0; frame_ack = 1'b0; sample_in = '0;
    s_valid = 1'b0; s_ack = 1'b0; s_in = '0;
    model_reset();
    #12;
    vectors++;
    if ({frame_valid, sample_ready, overrun, frame_cnt} !== 11'b0_1_0_00000000 || frame_out !== '0) begin
      errors++;
      $display("FAIL reset_state: got v%b r%b o%b c%0d expected v0 r1 o0 c0", frame_valid, sample_ready, overrun, frame_cnt);
    end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sample_in = DW'($urandom); sample_valid = 1'b1;
      cyc();
      vectors++;
      if ({frame_valid, sample_ready, overrun, frame_cnt} !== exp_status()) begin
        errors++;
        $display("FAIL prefill_status[%0d]: got %h expected %h", i, {frame_valid, sample_ready, overrun, frame_cnt}, exp_status());
      end
    end
    sample_valid = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({frame_valid, sample_ready, overrun, frame_cnt} !== exp_status() || frame_out !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got %h expected %h", {frame_valid, sample_ready, overrun, frame_cnt}, exp_status());
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_single_frame();
    for (int i = 0; i < FL; i++) begin
      sample_in = DW'(i); sample_valid = 1'b1;
      cyc();
      vectors++;
      if ({frame_valid, sample_ready, overrun, frame_cnt} !== exp_status()) begin
        errors++;
        $display("FAIL fill_status[%0d]: got %h expected %h", i, {frame_valid, sample_ready, overrun, frame_cnt}, exp_status());
      end
    end
    sample_valid = 1'b0;
    vectors++;
    if (frame_out !== exp_frame()) begin
      errors++;
      $display("FAIL ramp_frame: got %h.. expected %h..", frame_out[63:0], exp_frame() >> 0);
    end
    vectors++;
    if (frame_out[0 +: DW] !== 16'h0000 || frame_out[(FL-1)*DW +: DW] !== 16'h03FF || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL ramp_ends: got %h %h cnt %0d expected 0000 03ff cnt 1", frame_out[0 +: DW], frame_out[(FL-1)*DW +: DW], frame_cnt);
    end
  endtask

  task automatic test_ack_with_valid();
    sample_in = DW'($urandom); sample_valid = 1'b1; frame_ack = 1'b1;
    cyc();
    sample_valid = 1'b0; frame_ack = 1'b0;
    vectors++;
    if ({frame_valid, sample_ready, overrun, frame_cnt} !== exp_status()) begin
      errors++;
      $display("FAIL ack_with_valid: got %h expected %h", {frame_valid, sample_ready, overrun, frame_cnt}, exp_status());
    end
  endtask

  task automatic test_ack_in_fill_signed();
    int base;
    base = mq.size();
    for (int j = 0; j < FL - base; j++) begin
      sample_valid = 1'b1;
      sample_in = (j == 5) ? 16'h8000 : (j == 6) ? 16'hFFFF : DW'($urandom);
      frame_ack = (j == 100);
      cyc();
      frame_ack = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        sample_valid = 1'b0;
        cyc();
      end
      vectors++;
      if ({frame_valid, sample_ready, overrun, frame_cnt} !== exp_status()) begin
        errors++;
        $display("FAIL fill2_status[%0d]: got %h expected %h", j, {frame_valid, sample_ready, overrun, frame_cnt}, exp_status());
      end
    end
    sample_valid = 1'b0;
    vectors++;
    if (frame_out !== exp_frame()) begin
      errors++;
      $display("FAIL random_frame: got %h expected %h", frame_out[255:0], exp_frame() & {256{1'b1}});
    end
    vectors++;
    if (frame_out[(base+5)*DW +: DW] !== 16'h8000 || frame_out[(base+6)*DW +: DW] !== 16'hFFFF) begin
      errors++;
      $display("FAIL signed_exact: got %h %h expected 8000 ffff", frame_out[(base+5)*DW +: DW], frame_out[(base+6)*DW +: DW]);
    end
  endtask

  task automatic test_overrun();
    logic [FL*DW-1:0] snap;
    snap = frame_out;
    for (int k = 0; k < 5; k++) begin
      sample_in = DW'($urandom); sample_valid = 1'b1;
      cyc();
      vectors++;
      if ({frame_valid, sample_ready, overrun, frame_cnt} !== exp_status() || frame_out !== snap) begin
        errors++;
        $display("FAIL overrun_hold[%0d]: got %h expected %h", k, {frame_valid, sample_ready, overrun, frame_cnt}, exp_status());
      end
    end
    sample_valid = 1'b0; frame_ack = 1'b1;
    cyc();
    frame_ack = 1'b0;
    vectors++;
    if ({frame_valid, sample_ready, overrun, frame_cnt} !== exp_status()) begin
      errors++;
      $display("FAIL ack_release: got %h expected %h", {frame_valid, sample_ready, overrun, frame_cnt}, exp_status());
    end
  endtask

  task automatic test_back_to_back();
    while (!m_full) begin
      sample_in = DW'($urandom); sample_valid = 1'b1;
      cyc();
    end
    sample_valid = 1'b0;
    vectors++;
    if ({frame_valid, sample_ready, overrun, frame_cnt} !== exp_status() || frame_out !== exp_frame()) begin
      errors++;
      $display("FAIL back_to_back: got %h expected %h", {frame_valid, sample_ready, overrun, frame_cnt}, exp_status());
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0]      cur [SFL];
    logic [SFL*DW-1:0]  se;
    int                 kept;
    for (int f = 0; f < 256; f++) begin
`ifdef LOADER_OVERLAP_EN
      kept = (f == 0) ? 0 : SFL/2;
      for (int i = 0; i < kept; i++) cur[i] = cur[i + SFL/2];
`else
      kept = 0;
`endif
      for (int i = kept; i < SFL; i++) begin
        cur[i] = DW'($urandom);
        s_in = cur[i]; s_valid = 1'b1;
        @(posedge clk); #1;
      end
      s_valid = 1'b0;
      for (int i = 0; i < SFL; i++) se[i*DW +: DW] = cur[i];
      vectors++;
      if (s_fvalid !== 1'b1 || s_frame !== se || s_cnt !== 8'((f + 1) % 256)) begin
        errors++;
        $display("FAIL wrap_frame[%0d]: got v%b %h c%0d expected v1 %h c%0d", f, s_fvalid, s_frame, s_cnt, se, (f + 1) % 256);
      end
      s_ack = 1'b1;
      @(posedge clk); #1;
      s_ack = 1'b0;
    end
    vectors++;
    if (s_cnt !== 8'd0 || s_ready !== 1'b1 || s_ovr !== 1'b0) begin
      errors++;
      $display("FAIL wrap_final: got c%0d r%b o%b expected c0 r1 o0", s_cnt, s_ready, s_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ack_with_valid();
    test_ack_in_fill_signed();
    test_overrun();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/signal_frame_loader.md
# signal_frame_loader

Input staging block ahead of the 1-D CNN pipeline. It accepts a stream of signed 16-bit vibration samples over a valid/ready handshake, packs FRAME_LEN samples into the flat frame bus that drives the convolution layer's `signal` input, and holds that frame stable until the downstream controller acknowledges the classification. It also flags any samples offered while no space was available.

## Interface
- DATA_WIDTH, 16, bits per sample
- FRAME_LEN, 1024, samples per frame; even, ≥ 4
- CNT_W, 11, frame-index counter width; must hold FRAME_LEN
- clk  input  1  rising-edge clock, the only clock
- reset  input  1  asynchronous, active-low reset
- sample_in  input  DATA_WIDTH  signed sample, two's complement
- sample_valid  input  1  sample_in is valid this cycle
- sample_ready  output  1  loader can accept a sample this cycle
- frame_ack  input  1  one-cycle pulse: downstream has finished with the frame
- frame_out  output  FRAME_LEN*DATA_WIDTH  packed frame; sample i sits at [i*DATA_WIDTH +: DATA_WIDTH]
- frame_valid  output  1  frame_out is complete and stable
- frame_cnt  output  8  number of frames completed, wraps 255→0
- overrun  output  1  sticky error flag

## Operation
- Two states: FILL and FULL. Reset enters FILL.
- FILL:
  - sample_ready = 1, frame_valid = 0.
  - A sample is accepted when sample_valid and sample_ready are both high at a clk rising edge.
  - The accepted sample is written to slot wr_idx, and wr_idx increments.
  - The accept that writes slot FRAME_LEN-1 moves the block to FULL, sets wr_idx to 0 and increments frame_cnt.
- FULL:
  - sample_ready = 0, frame_valid = 1, frame_out frozen.
  - frame_ack = 1 returns the block to FILL.
  - Without overlap, slot contents are kept but are not guaranteed valid until rewritten.
- frame_ack in FILL is ignored.
- sample_valid = 1 while sample_ready = 0 (FULL state) sets overrun. That sample is dropped. overrun clears only on reset.
- sample_ready and frame_valid are registered state decodes and are always complementary.
- Samples are stored verbatim: no scaling, saturation or sign change.
- Reset, at any time including mid-frame:
  - frame_out = 0, wr_idx = 0, frame_cnt = 0, overrun = 0.
  - frame_valid = 0, sample_ready = 1.
  - The partial frame is discarded.

## Timing
- Accept-to-storage latency is 1 cycle: the slot updates on the accepting edge.
- Last accept at edge N: frame_valid = 1 and sample_ready = 0 from edge N onward.
- frame_ack sampled high at edge M: frame_valid = 0 and sample_ready = 1 from edge M onward. The next sample can therefore be accepted at edge M+1.
- The minimum frame period is FRAME_LEN accepted cycles plus 1 cycle in FULL.
- frame_ack and sample_valid high at the same edge in FULL: the ack is taken, the sample is not accepted, and overrun is set.
- The producer must hold sample_in and sample_valid until it sees sample_ready.

## Configuration
- Macro: LOADER_OVERLAP_EN.
- Defined — 50 % overlap:
  - On frame_ack, slots FRAME_LEN/2…FRAME_LEN-1 are copied into slots 0…FRAME_LEN/2-1.
  - wr_idx is set to FRAME_LEN/2.
  - Each subsequent frame therefore needs only FRAME_LEN/2 new samples.
  - The first frame after reset still needs FRAME_LEN samples.
- Undefined — no overlap:
  - frame_ack sets wr_idx = 0, and every frame needs FRAME_LEN new samples.
  - The copy logic is absent.

## Test plan
- Reset behaviour: assert reset mid-stream after 300 samples → all outputs at their reset values immediately; the next 1024 samples form frame 0 and frame_cnt = 1.
- Single full frame, no overlap: stream samples 0…1023 with sample_in = i, valid held high.
  - frame_valid rises on the edge that accepts i = 1023.
  - frame_out slice i equals i; slice 0 = 0x0000, slice 1023 = 0x03FF.
  - frame_cnt = 1.
- Back-pressure and overrun:
  - Hold sample_valid high in FULL for 5 cycles → sample_ready = 0, overrun = 1, frame_out unchanged.
  - Then pulse frame_ack → sample_ready = 1 on the next cycle.
- Ack corner cases: frame_ack pulsed in FILL at sample 100 → ignored, with fill continuing to 1024. Ack concurrent with valid in FULL → sample dropped and overrun set.
- Overlap (LOADER_OVERLAP_EN, FRAME_LEN = 8): feed 0…7, ack, then feed 8…11 → second frame is 4,5,6,7,8,9,10,11; frame_cnt = 2.
- Signed and wrap checks:
  - Samples 0x8000 and 0xFFFF are stored bit-exact.
  - 256 consecutive frames with FRAME_LEN = 4 → frame_cnt wraps to 0.
